// File: rtl/seg7_scan_decoder.sv
// Monitor for a multiplexed active-low 7-segment bus: settles, decodes and reassembles HH:MM.
// Optional macro SEG7_DP_CAPTURE_EN captures decimal points alongside digits.
module seg7_scan_decoder #(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] led7_an_i,
  input  logic [7:0] led7_seg_i,
  output logic [3:0] hr_left_o,
  output logic [3:0] hr_right_o,
  output logic [3:0] min_left_o,
  output logic [3:0] min_right_o,
  output logic [3:0] dp_o,
  output logic       frame_o,
  output logic       changed_o,
  output logic       decode_err_o,
  output logic       anode_err_o,
  output logic       stale_o
);

  localparam logic [7:0] SETTLE_N = 8'(SETTLE_CYCLES);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_e;

  state_e          state_q;
  logic [7:0]      cnt_q;
  logic [11:0]     prev_q;
  logic [3:0]      seen_q;
  logic [3:0][3:0] shadow_q;
  logic [3:0][3:0] dig_q;
  logic            multi_q;
  logic            cap_err_q;
  logic [TW-1:0]   tcnt_q;

  logic [3:0]  an_low;
  logic        multi, single, same, hold_same, cap, frame_rdy;
  logic [7:0]  seg_m;
  logic [11:0] cur;
  logic [1:0]  slot;
  logic [7:0]  cnt_n;
  logic [4:0]  dec;
  logic        unused_in;

  // Returns {err, digit}; input is the lit-segment vector g..a.
  function automatic logic [4:0] decode(input logic [6:0] lit);
    case (lit)
      7'b0111111: decode = 5'h00;
      7'b0000110: decode = 5'h01;
      7'b1011011: decode = 5'h02;
      7'b1001111: decode = 5'h03;
      7'b1100110: decode = 5'h04;
      7'b1101101: decode = 5'h05;
      7'b1111101: decode = 5'h06;
      7'b0000111: decode = 5'h07;
      7'b1111111: decode = 5'h08;
      7'b1101111: decode = 5'h09;
      7'b0000000: decode = 5'h0F;
      default:    decode = 5'h1E;
    endcase
  endfunction

  assign an_low = ~led7_an_i[3:0];
  assign multi  = (an_low & (an_low - 4'd1)) != 4'd0;
  assign single = (an_low != 4'd0) && !multi;

`ifdef SEG7_DP_CAPTURE_EN
  assign seg_m     = led7_seg_i;
  assign unused_in = ^led7_an_i[7:4];
`else
  // dp masked so a toggling point never disturbs digit settling
  assign seg_m     = {1'b1, led7_seg_i[6:0]};
  assign unused_in = ^{led7_an_i[7:4], led7_seg_i[7]};
`endif

  assign cur       = {led7_an_i[3:0], seg_m};
  assign same      = (cur == prev_q);
  assign dec       = decode(~led7_seg_i[6:0]);
  assign hold_same = (state_q == HOLD) && same;
  assign frame_rdy = (seen_q == 4'hF);

  always_comb begin
    slot = 2'd0;
    for (int i = 0; i < 4; i++)
      if (an_low[i]) slot = 2'(i);
  end

  always_comb begin
    cnt_n = 8'd1;
    if (state_q == SETTLE && same) cnt_n = cnt_q + 8'd1;
  end

  assign cap = single && !hold_same && (cnt_n >= SETTLE_N);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      prev_q       <= '1;
      seen_q       <= '0;
      shadow_q     <= {4{4'hF}};
      dig_q        <= {4{4'hF}};
      multi_q      <= 1'b0;
      cap_err_q    <= 1'b0;
      tcnt_q       <= '0;
      frame_o      <= 1'b0;
      changed_o    <= 1'b0;
      decode_err_o <= 1'b0;
      anode_err_o  <= 1'b0;
      stale_o      <= 1'b1;
    end else begin
      prev_q      <= cur;
      multi_q     <= multi;
      anode_err_o <= multi & ~multi_q;

      if (!single) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else if (!hold_same) begin
        if (cap) begin
          state_q <= HOLD;
          cnt_q   <= '0;
        end else begin
          state_q <= SETTLE;
          cnt_q   <= cnt_n;
        end
      end

      // error pulse delayed one edge so it lines up with the frame outputs
      cap_err_q    <= cap & dec[4];
      decode_err_o <= cap_err_q;
      if (cap) shadow_q[slot] <= dec[3:0];
      seen_q <= (frame_rdy ? 4'h0 : seen_q) | (cap ? an_low : 4'h0);

      frame_o   <= frame_rdy;
      changed_o <= frame_rdy && (shadow_q != dig_q);
      if (frame_rdy) dig_q <= shadow_q;

      if (frame_rdy) begin
        tcnt_q  <= '0;
        stale_o <= 1'b0;
      end else if (tcnt_q != TMAX) begin
        tcnt_q <= tcnt_q + 1'b1;
        if (tcnt_q == TMAX - 1'b1) stale_o <= 1'b1;
      end
    end
  end

`ifdef SEG7_DP_CAPTURE_EN
  logic [3:0] dp_sh_q, dp_q;
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      dp_sh_q <= '0;
      dp_q    <= '0;
    end else begin
      if (cap) dp_sh_q[slot] <= ~led7_seg_i[7];
      if (frame_rdy) dp_q <= dp_sh_q;
    end
  end
  assign dp_o = dp_q;
`else
  assign dp_o = 4'b0000;
`endif

  assign hr_left_o   = dig_q[3];
  assign hr_right_o  = dig_q[2];
  assign min_left_o  = dig_q[1];
  assign min_right_o = dig_q[0];

endmodule

// File: doc/seg7_scan_decoder.md
# seg7_scan_decoder

Receive-side counterpart of the multiplexed 7-segment display driver: watches the active-low anode and segment buses, waits for each digit to settle, decodes the segment pattern back to BCD and reassembles the four clock digits (HH:MM). Sits in the self-test/monitor path, attached to the driver outputs, so the bench and the on-chip test logic can read displayed time as numbers. It also flags undecodable patterns, illegal anode patterns and a stalled scan.

## Interface
- SETTLE_CYCLES, 4: consecutive identical cycles required before a digit is captured (1..255).
- TIMEOUT_CYCLES, 2000000: cycles without a completed frame before stale_o asserts.

- clk_i  in  1  system clock.
- rst_i  in  1  reset, synchronous, active-low.
- led7_an_i  in  8  anodes, active-low; bit0=min_right, bit1=min_left, bit2=hr_right, bit3=hr_left, bits7:4 unused.
- led7_seg_i  in  8  segments, active-low, {dp,g,f,e,d,c,b,a}.
- hr_left_o, hr_right_o, min_left_o, min_right_o  out  4 each  decoded digits.
- dp_o  out  4  decimal-point state per digit (bit order as anodes 3:0).
- frame_o  out  1  one-cycle pulse: new complete frame on the digit outputs.
- changed_o  out  1  one-cycle pulse with frame_o when any digit differs from the previous frame.
- decode_err_o  out  1  one-cycle pulse: captured pattern not in the decode table.
- anode_err_o  out  1  one-cycle pulse: more than one of anodes 3:0 low.
- stale_o  out  1  level: no frame within TIMEOUT_CYCLES.

## Operation
- Decode table (g..a, 1 = lit): 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111; all off = blank -> 4'hF; anything else -> 4'hE plus decode_err_o.
- FSM states: IDLE (no single anode of 3:0 low), SETTLE (counting), HOLD (digit captured, waiting for change).
- IDLE -> SETTLE when exactly one of anodes 3:0 is low; counter loads 1.
- SETTLE: counter increments while {an,seg} equals previous cycle; any change restarts at 1 (new anode) or returns to IDLE (no anode). Counter reaching SETTLE_CYCLES -> capture digit into shadow slot, set slot's seen bit, go HOLD.
- HOLD: {an,seg} change -> SETTLE (new value) or IDLE. Same anode with new segment pattern is recaptured after settling, overwriting the slot.
- Anodes 7:4 ignored entirely. Two or more of 3:0 low -> anode_err_o pulse once per entry, treated as IDLE.
- When all four seen bits are set: shadow copied to outputs, frame_o pulses, changed_o if outputs differ, seen bits clear, timeout counter clears, stale_o clears.
- Timeout counter increments every cycle without a frame; reaching TIMEOUT_CYCLES sets stale_o (sticky until next frame); counter saturates.

## Timing
- Reset (rst_i low at edge): digits 4'hF, dp_o 0, frame_o/changed_o/decode_err_o/anode_err_o 0, stale_o 1, FSM IDLE, seen bits 0, counters 0. Reset mid-frame discards partial shadow.
- Inputs are in the clk_i domain; no synchroniser.
- Capture edge: the SETTLE_CYCLES-th consecutive cycle of a stable value (value first present at cycle t -> captured at edge ending cycle t+SETTLE_CYCLES-1).
- Frame completion: outputs and frame_o/changed_o registered on the edge after the completing capture; decode_err_o on the same edge as outputs for that slot's capture.
- First frame after reset always pulses changed_o only if a digit differs from 4'hF.

## Configuration
- SEG7_DP_CAPTURE_EN defined: dp bit captured with each digit, dp_o updated at frame completion; dp excluded from decode and from changed_o.
- Not defined: dp bit ignored (masked before stability compare), dp_o tied 4'b0000.

## Test plan
- Reset, scan 1,2,3,4 on anodes 3..0, 8 cycles each, SETTLE_CYCLES=4 -> frame_o one cycle, hr_left=1 hr_right=2 min_left=3 min_right=4, changed_o=1, stale_o=0.
- Repeat identical frame -> frame_o=1, changed_o=0; then min_right 4->5 -> changed_o=1, min_right_o=5.
- Digit held 3 cycles only (SETTLE_CYCLES=4) -> no capture, no frame_o until it is rescanned for 4 cycles.
- Pattern 1110000 on anode 0 -> decode_err_o pulse, min_right_o=4'hE at frame; an=8'b11111100 -> anode_err_o pulse, no capture.
- No scan for TIMEOUT_CYCLES (set to 100) -> stale_o=1 at cycle 100; next full frame -> stale_o=0.
- rst_i low after two digits captured, then two remaining digits scanned -> no frame_o until all four rescanned; with SEG7_DP_CAPTURE_EN, dp lit on hr_right -> dp_o=4'b0100.
